tx_data_unit_summer2021_hust: RTL and testbench



---
 rtl/tx_data_unit_summer2021_hust.sv | 63 ++++++
 tb/tb_tx_data_unit_summer2021_hust.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/tx_data_unit_summer2021_hust.sv
`default_nettype none
// ============================================================================
// Module   : tx_data_unit_summer2021_hust
// Purpose  : UART transmit datapath. Builds a frame of start bit, data bits
//            (LSB first), parity bit and stop bit in a shift register, then
//            shifts it out on Tx one bit per ShiftOut clock. Bit timing and
//            sequencing come from an external control unit.
// Ports    : Clock    - sole clock, rising edge
//            Reset    - asynchronous active-low reset (register -> all ones)
//            Data     - parallel word, sampled only on a Load edge
//            Load     - load a new frame (wins over ShiftOut)
//            ShiftOut - shift frame right by one bit, filling with ones
//            Parity   - 0 = even parity, 1 = odd parity (sampled at load)
//            Tx       - serial output, idle high
// Revision : 1.0 - initial release
// ============================================================================
module tx_data_unit_summer2021_hust #(
    parameter int DataLength = 9
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DataLength-1:0] Data,
    input  logic                  Load,
    input  logic                  ShiftOut,
    input  logic                  Parity,
    output logic                  Tx
);

    localparam int FRAME_W = DataLength + 3;

    logic [FRAME_W-1:0] shift_reg_q;
    logic [FRAME_W-1:0] shift_reg_d;
    logic               parity_bit;

    // Even parity makes data+parity hold an even count of ones; odd flips it.
    always_comb begin
        parity_bit = Parity ? ~(^Data) : (^Data);
    end

    // Load has priority over ShiftOut; shifting fills from the top with ones
    // so the line idles high once the frame has been sent.
    always_comb begin
        shift_reg_d = shift_reg_q;
        if (Load) begin
            shift_reg_d = {1'b1, parity_bit, Data, 1'b0};
        end else if (ShiftOut) begin
            shift_reg_d = {1'b1, shift_reg_q[FRAME_W-1:1]};
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            shift_reg_q <= '1;
        end else begin
            shift_reg_q <= shift_reg_d;
        end
    end

    // Tx comes straight from the register LSB, no extra output flop.
    assign Tx = shift_reg_q[0];

endmodule
`default_nettype wire

// File: tb/tb_tx_data_unit_summer2021_hust.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_data_unit_summer2021_hust
// Purpose  : Directed self-checking bench for the UART transmit datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_data_unit_summer2021_hust;

    localparam int DATA_W  = 9;
    localparam int FRAME_W = DATA_W + 3;

    logic              Clock;
    logic              Reset;
    logic [DATA_W-1:0] Data;
    logic              Load;
    logic              ShiftOut;
    logic              Parity;
    logic              Tx;

    int checks;
    int errors;

    tx_data_unit_summer2021_hust #(.DataLength(DATA_W)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Data     (Data),
        .Load     (Load),
        .ShiftOut (ShiftOut),
        .Parity   (Parity),
        .Tx       (Tx)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; leave time 1 unit after it for sampling/driving.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Shift n times with ShiftOut high, checking Tx against the hand-given
    // expected bit string (bit i = Tx after shift i+1).
    task automatic shift_seq(input string tag, input int n, input logic [31:0] exp_bits);
        ShiftOut = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            check_eq($sformatf("%s_bit%0d", tag, i), {31'd0, Tx}, {31'd0, exp_bits[i]});
        end
        ShiftOut = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        Reset    = 1'b1;
        Load     = 1'b0;
        ShiftOut = 1'b0;
        Data     = '0;
        Parity   = 1'b0;

        // Asynchronous reset, asserted away from any clock edge.
        #3;
        Reset = 1'b0;
        #1;
        check_eq("reset_tx", {31'd0, Tx}, 32'd1);
        check_eq("reset_reg", {20'd0, dut.shift_reg_q}, 32'hFFF);
        step();
        Reset = 1'b1;
        step();
        check_eq("post_reset_tx", {31'd0, Tx}, 32'd1);

        // Odd parity frame: 0xAAA.
        Data   = 9'b101010101;
        Parity = 1'b1;
        Load   = 1'b1;
        step();
        Load   = 1'b0;
        check_eq("odd_reg", {20'd0, dut.shift_reg_q}, 32'hAAA);
        check_eq("odd_start", {31'd0, Tx}, 32'd0);
        // D0..D8 = 1,0,1,0,1,0,1,0,1 ; parity 0 ; stop 1 ; idle 1,1,1
        shift_seq("odd", 14, 32'b11_1101_0101_0101);

        // Even parity frame: 0xFC4, with Data/Parity disturbed mid-shift.
        Data   = 9'b111100010;
        Parity = 1'b0;
        Load   = 1'b1;
        step();
        Load   = 1'b0;
        check_eq("even_reg", {20'd0, dut.shift_reg_q}, 32'hFC4);
        check_eq("even_start", {31'd0, Tx}, 32'd0);
        // First 3 bits: D0..D2 = 0,1,0
        shift_seq("even_a", 3, 32'b010);
        Data   = 9'h000;
        Parity = 1'b1;
        // Remaining: D3..D8 = 0,0,1,1,1,1 ; parity 1 ; stop 1 ; idle 1
        shift_seq("even_b", 9, 32'b1_1111_1100);

        // Simultaneous Load and ShiftOut: load wins, no shift.
        Data     = 9'h0FF;
        Parity   = 1'b0;
        Load     = 1'b1;
        ShiftOut = 1'b1;
        step();
        check_eq("ldsh_reg", {20'd0, dut.shift_reg_q}, 32'h9FE);
        check_eq("ldsh_tx", {31'd0, Tx}, 32'd0);
        // Held Load keeps reloading: stays on the start bit.
        step();
        check_eq("ldhold_tx", {31'd0, Tx}, 32'd0);
        check_eq("ldhold_reg", {20'd0, dut.shift_reg_q}, 32'h9FE);
        Load     = 1'b0;
        ShiftOut = 1'b0;
        // 0x9FE: D0..D3 = 1,1,1,1
        shift_seq("ldsh", 4, 32'b1111);

        // Load mid-frame replaces the frame at once: 9 ones, odd -> 0xBFE.
        Data   = 9'h1FF;
        Parity = 1'b1;
        Load   = 1'b1;
        step();
        Load   = 1'b0;
        check_eq("midload_tx", {31'd0, Tx}, 32'd0);
        check_eq("midload_reg", {20'd0, dut.shift_reg_q}, 32'hBFE);
        // D0..D8 all 1, parity 0, stop 1
        shift_seq("midload", 11, 32'b101_1111_1111);

        // Reset mid-frame after 4 shifts of 0xAAA.
        Data   = 9'b101010101;
        Parity = 1'b1;
        Load   = 1'b1;
        step();
        Load   = 1'b0;
        shift_seq("prerst", 4, 32'b0101);
        #2;
        Reset = 1'b0;
        #1;
        check_eq("midrst_tx", {31'd0, Tx}, 32'd1);
        check_eq("midrst_reg", {20'd0, dut.shift_reg_q}, 32'hFFF);
        step();
        Reset = 1'b1;
        shift_seq("postrst", 5, 32'b11111);
        check_eq("postrst_reg", {20'd0, dut.shift_reg_q}, 32'hFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
